// File: rtl/unary_add_n_if.sv
// Control/data bundle for the unary accumulator: phase and mode controls in,
// serial pulse outputs and count status back out.
interface unary_add_n_if #(
  parameter int N_IN = 4,
  parameter int CAP  = 8
);
  localparam int CW = $clog2(CAP + 1);

  logic            en;
  logic            clr;
  logic            read_or_write;
  logic            sat_mode;
  logic [N_IN-1:0] din;
  logic            dout;
  logic            C;
  logic            done;
  logic            busy;
  logic [CW-1:0]   count_o;

  modport master (
    output en, clr, read_or_write, sat_mode, din,
    input  dout, C, done, busy, count_o
  );

  modport slave (
    input  en, clr, read_or_write, sat_mode, din,
    output dout, C, done, busy, count_o
  );
endinterface

// File: rtl/unary_add_n.sv
// N-input unary pulse-count accumulator: sums high lanes modulo CAP+1 (or
// clamps at CAP) and drains the stored count as a train of dout pulses.
module unary_add_n_lane #(
  parameter int AW = 4
) (
  input  logic          bit_i,
  input  logic [AW-1:0] acc_i,
  output logic [AW-1:0] acc_o
);
  assign acc_o = acc_i + AW'(bit_i);
endmodule

module unary_add_n #(
  parameter int N_IN = 4,
  parameter int CAP  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  unary_add_n_if.slave bus
);
  localparam int CW = $clog2(CAP + 1);
  // Popcount and sum carry one extra bit so count + N_IN never overflows.
  localparam logic [CW:0]   CAP_X = (CW+1)'(CAP);
  localparam logic [CW:0]   CAPP1 = (CW+1)'(CAP + 1);
  localparam logic [CW-1:0] CAP_W = CW'(CAP);

  if (N_IN > CAP + 1 || CAP < 1) begin : g_bad_param
    $error("unary_add_n: need CAP >= 1 and N_IN <= CAP+1");
  end

  logic [N_IN:0][CW:0] acc;
  logic [CW:0]         k;
  logic [CW:0]         sum;

  logic [CW-1:0] count_q, count_d;
  logic          dout_q, dout_d;
  logic          c_q, c_d;
  logic          done_q, done_d;

  assign acc[0] = '0;

  // Ripple popcount: each lane adds its own bit to the running tally.
  for (genvar g = 0; g < N_IN; g++) begin : g_lane
    unary_add_n_lane #(.AW(CW + 1)) u_lane (
      .bit_i (bus.din[g]),
      .acc_i (acc[g]),
      .acc_o (acc[g+1])
    );
  end

  assign k   = acc[N_IN];
  assign sum = {1'b0, count_q} + k;

  always_comb begin
    count_d = count_q;
    dout_d  = 1'b0;
    c_d     = 1'b0;
    done_d  = 1'b0;
    if (bus.clr) begin
      count_d = '0;
    end else if (bus.en) begin
      if (!bus.read_or_write) begin
        if (sum > CAP_X) begin
          c_d     = 1'b1;
          count_d = bus.sat_mode ? CAP_W : CW'(sum - CAPP1);
        end else begin
          count_d = sum[CW-1:0];
        end
      end else if (count_q != '0) begin
        dout_d  = 1'b1;
        done_d  = (count_q == CW'(1));
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout    = dout_q;
  assign bus.C       = c_q;
  assign bus.done    = done_q;
  assign bus.busy    = (count_q != '0);
  assign bus.count_o = count_q;
endmodule

// File: tb/tb_unary_add_n.sv
// Bench for unary_add_n: directed vector table, reset-mid-drain sequence and
// a randomized run against a count-level reference model.
module tb_unary_add_n;
  localparam int N_IN = 4;
  localparam int CAP  = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  unary_add_n_if #(.N_IN(N_IN), .CAP(CAP)) bus ();

  unary_add_n #(.N_IN(N_IN), .CAP(CAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic            en, clr, rw, sat;
    logic [N_IN-1:0] din;
    int              cnt;
    logic            dout, c, done;
  } vec_t;

  vec_t tbl[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(logic en, logic clr, logic rw, logic sat,
                              logic [N_IN-1:0] din, int cnt,
                              logic dout, logic c, logic done);
    vec_t v;
    v.en = en; v.clr = clr; v.rw = rw; v.sat = sat; v.din = din;
    v.cnt = cnt; v.dout = dout; v.c = c; v.done = done;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic clr, logic rw, logic sat, logic [N_IN-1:0] din);
    bus.en = en; bus.clr = clr; bus.read_or_write = rw;
    bus.sat_mode = sat; bus.din = din;
  endtask

  task automatic check_all(string tag, int cnt, logic dout, logic c, logic done);
    check({tag, ".cnt"},  int'(bus.count_o), cnt);
    check({tag, ".dout"}, int'(bus.dout), int'(dout));
    check({tag, ".C"},    int'(bus.C), int'(c));
    check({tag, ".done"}, int'(bus.done), int'(done));
    check({tag, ".busy"}, int'(bus.busy), int'(cnt != 0));
  endtask

  // Reference state: the count as a plain integer.
  int m_cnt;
  logic e_dout, e_c, e_done;

  task automatic model_step(logic en, logic clr, logic rw, logic sat, logic [N_IN-1:0] din);
    int s;
    e_dout = 1'b0; e_c = 1'b0; e_done = 1'b0;
    if (clr) m_cnt = 0;
    else if (en) begin
      if (!rw) begin
        s = m_cnt + $countones(din);
        if (s > CAP) begin
          e_c = 1'b1;
          m_cnt = sat ? CAP : s - (CAP + 1);
        end else m_cnt = s;
      end else if (m_cnt > 0) begin
        e_dout = 1'b1;
        e_done = (m_cnt == 1);
        m_cnt--;
      end
    end
  endtask

  initial begin
    drive(0, 0, 0, 0, '0);
    // idle after reset
    tbl.push_back(mk(0,0,0,0,4'b0000, 0,0,0,0));
    // wrap mode
    tbl.push_back(mk(1,0,0,0,4'b0111, 3,0,0,0));
    tbl.push_back(mk(1,0,0,0,4'b1111, 7,0,0,0));
    tbl.push_back(mk(1,0,0,0,4'b1111, 2,0,1,0));
    tbl.push_back(mk(1,0,0,0,4'b0000, 2,0,0,0));
    tbl.push_back(mk(1,1,0,0,4'b1111, 0,0,0,0));
    // saturate mode
    tbl.push_back(mk(1,0,0,1,4'b0111, 3,0,0,0));
    tbl.push_back(mk(1,0,0,1,4'b1111, 7,0,0,0));
    tbl.push_back(mk(1,0,0,1,4'b1111, 8,0,1,0));
    tbl.push_back(mk(1,0,0,1,4'b0001, 8,0,1,0));
    tbl.push_back(mk(1,0,0,1,4'b0000, 8,0,0,0));
    tbl.push_back(mk(1,1,1,1,4'b1111, 0,0,0,0));
    // drain of 3 over 5 cycles
    tbl.push_back(mk(1,0,0,0,4'b0111, 3,0,0,0));
    tbl.push_back(mk(1,0,1,0,4'b1111, 2,1,0,0));
    tbl.push_back(mk(1,0,1,0,4'b1111, 1,1,0,0));
    tbl.push_back(mk(1,0,1,0,4'b1111, 0,1,0,1));
    tbl.push_back(mk(1,0,1,0,4'b1111, 0,0,0,0));
    tbl.push_back(mk(1,0,1,0,4'b1111, 0,0,0,0));
    // drain of 4 with an enable gap
    tbl.push_back(mk(1,0,0,0,4'b1111, 4,0,0,0));
    tbl.push_back(mk(1,0,1,0,4'b0000, 3,1,0,0));
    tbl.push_back(mk(0,0,1,0,4'b0000, 3,0,0,0));
    tbl.push_back(mk(1,0,1,0,4'b0000, 2,1,0,0));
    tbl.push_back(mk(1,0,1,0,4'b0000, 1,1,0,0));
    tbl.push_back(mk(1,0,1,0,4'b0000, 0,1,0,1));
    // switch back to accumulate mid-drain keeps residual
    tbl.push_back(mk(1,0,0,0,4'b0011, 2,0,0,0));
    tbl.push_back(mk(1,0,1,0,4'b0000, 1,1,0,0));
    tbl.push_back(mk(1,0,0,0,4'b0111, 4,0,0,0));
    // carry then emit clears C; en=0 holds count
    tbl.push_back(mk(1,0,0,0,4'b1111, 8,0,0,0));
    tbl.push_back(mk(1,0,0,0,4'b1111, 3,0,1,0));
    tbl.push_back(mk(1,0,1,0,4'b1111, 2,1,0,0));
    tbl.push_back(mk(0,0,0,0,4'b1111, 2,0,0,0));
    tbl.push_back(mk(1,1,0,0,4'b1111, 0,0,0,0));

    #12;
    check_all("reset", 0, 0, 0, 0);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].rw, tbl[i].sat, tbl[i].din);
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), tbl[i].cnt, tbl[i].dout, tbl[i].c, tbl[i].done);
    end

    // reset mid-drain: count 5, two pulses, then async reset between edges
    drive(1, 0, 0, 0, 4'b1111); @(posedge clk); #1;
    drive(1, 0, 0, 0, 4'b0001); @(posedge clk); #1;
    check("mid.load", int'(bus.count_o), 5);
    drive(1, 0, 1, 0, 4'b0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all("mid.pulse2", 3, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1 check_all("mid.rst", 0, 0, 0, 0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_all($sformatf("mid.after%0d", i), 0, 0, 0, 0);
    end

    // randomized run against the reference model
    m_cnt = 0;
    for (int i = 0; i < 400; i++) begin
      logic en, clr, rw, sat;
      logic [N_IN-1:0] din;
      en  = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 19) == 0);
      rw  = ($urandom_range(0, 1) == 1);
      sat = ($urandom_range(0, 1) == 1);
      din = N_IN'($urandom);
      drive(en, clr, rw, sat, din);
      model_step(en, clr, rw, sat, din);
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", i), m_cnt, e_dout, e_c, e_done);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
